// File: rtl/pulse_sel_n.sv
// pulse_sel_n: N-channel max/min selector that emits an out pulse as long as the winning operand.
module pulse_sel_n #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N-1:0]           dav_,
  input  logic [N*W-1:0]         data,
  input  logic                   mode,
  output logic                   rfd,
  output logic                   out,
  output logic [$clog2(N)-1:0]   sel,
  output logic [W-1:0]           val
);
  localparam int S = $clog2(N);
  localparam int P = 1 << S;
  typedef enum logic [1:0] {IDLE, ACK, PULSE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, val_q, val_d;
  logic [S-1:0] sel_q, sel_d;
  logic [W-1:0] nv [1:2*P-1];
  logic [S-1:0] ni [1:2*P-1];
  logic [W-1:0] pad;
  logic pick;
  // Padding leaves hold a value that can never strictly beat a real operand, and their
  // higher index makes them lose ties, so a non-power-of-two N needs no valid bits.
  assign pad = {W{mode}};
  always_comb begin
    pick = 1'b0;
    for (int k = 0; k < P; k++) begin
      nv[P+k] = pad;
      ni[P+k] = S'(k);
    end
    for (int k = 0; k < N; k++) nv[P+k] = data[k*W +: W];
    for (int k = P - 1; k >= 1; k--) begin
      pick  = mode ? (nv[2*k+1] < nv[2*k]) : (nv[2*k+1] > nv[2*k]);
      nv[k] = pick ? nv[2*k+1] : nv[2*k];
      ni[k] = pick ? ni[2*k+1] : ni[2*k];
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: if (dav_ == '0) begin
        state_d = ACK;
        cnt_d   = nv[1];
        val_d   = nv[1];
        sel_d   = ni[1];
      end
      ACK: if (dav_ == '1) state_d = (cnt_q == '0) ? IDLE : PULSE;
      PULSE: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == W'(1)) ? IDLE : PULSE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      sel_q   <= sel_d;
    end
  end
  assign rfd = (state_q == IDLE);
  assign out = (state_q == PULSE);
  assign sel = sel_q;
  assign val = val_q;
endmodule

// File: tb/tb_pulse_sel_n.sv
// tb_pulse_sel_n: table-driven and randomized checks of pulse_sel_n with N=4, W=8.
module tb_pulse_sel_n;
  localparam int N = 4;
  localparam int W = 8;
  logic clock, reset, mode, rfd, out;
  logic [N-1:0] dav_;
  logic [N*W-1:0] data;
  logic [1:0] sel;
  logic [W-1:0] val;
  int n_vec, n_err;

  typedef struct {
    logic [31:0] d;
    logic        m;
    int          esel;
    int          eval;
    int          stag;
  } vec_t;
  vec_t vt [8];

  pulse_sel_n #(.N(N), .W(W)) dut (
    .clock(clock), .reset(reset), .dav_(dav_), .data(data),
    .mode(mode), .rfd(rfd), .out(out), .sel(sel), .val(val)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: find the extreme value, then the first channel carrying it.
  function automatic void ref_pick(input logic [31:0] d, input logic m, output int s, output int v);
    int ext;
    ext = m ? 255 : 0;
    for (int i = 0; i < N; i++) begin
      int x;
      x = int'(d[i*8 +: 8]);
      if (m ? (x < ext) : (x > ext)) ext = x;
    end
    s = -1;
    for (int i = N - 1; i >= 0; i--) if (int'(d[i*8 +: 8]) == ext) s = i;
    v = ext;
  endfunction

  task automatic run_txn(input logic [31:0] d, input logic m, input int esel, input int ev,
                         input int stag, input int hold);
    data = d;
    mode = m;
    if (stag > 0) begin
      dav_ = 4'b1110;
      repeat (stag) begin
        @(negedge clock);
        chk("partial_lo_rfd", rfd, 1);
        chk("partial_lo_out", out, 0);
      end
    end
    dav_ = '0;
    @(negedge clock);
    chk("cap_rfd", rfd, 0);
    chk("cap_out", out, 0);
    chk("cap_sel", sel, esel);
    chk("cap_val", val, ev);
    data = $urandom;
    mode = 1'($urandom);
    repeat (hold) begin
      @(negedge clock);
      chk("ack_rfd", rfd, 0);
      chk("ack_out", out, 0);
    end
    if (stag > 0) begin
      dav_ = 4'b0001;
      repeat (stag) begin
        @(negedge clock);
        chk("partial_hi_out", out, 0);
        chk("partial_hi_rfd", rfd, 0);
      end
    end
    dav_ = '1;
    for (int c = 0; c <= ev; c++) begin
      @(negedge clock);
      chk("pulse_out", out, (c < ev) ? 1 : 0);
      chk("pulse_rfd", rfd, (c >= ev) ? 1 : 0);
    end
    chk("held_sel", sel, esel);
    chk("held_val", val, ev);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    dav_ = '1;
    data = '0;
    mode = 1'b0;
    vt[0] = '{32'h0000_0703, 1'b0, 1, 7,   0};
    vt[1] = '{32'h0902_02C8, 1'b1, 1, 2,   0};
    vt[2] = '{32'h0500_0909, 1'b1, 2, 0,   0};
    vt[3] = '{32'hFF03_04FF, 1'b0, 0, 255, 0};
    vt[4] = '{32'h0A14_1405, 1'b0, 1, 20,  3};
    vt[5] = '{32'h0101_0101, 1'b1, 0, 1,   0};
    vt[6] = '{32'h6432_3C46, 1'b0, 3, 100, 1};
    vt[7] = '{32'h0000_0703, 1'b0, 1, 7,   3};
    repeat (2) @(negedge clock);
    chk("reset_rfd", rfd, 1);
    chk("reset_out", out, 0);
    chk("reset_sel", sel, 0);
    chk("reset_val", val, 0);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 8; i++) run_txn(vt[i].d, vt[i].m, vt[i].esel, vt[i].eval, vt[i].stag, i % 3);

    // Reset in the middle of a 100-cycle pulse once the counter has reached 40.
    data = 32'h0000_0064;
    mode = 1'b0;
    dav_ = '0;
    @(negedge clock);
    dav_ = '1;
    @(negedge clock);
    chk("mid_out_start", out, 1);
    repeat (60) @(negedge clock);
    chk("mid_out_at40", out, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_reset_out", out, 0);
    chk("mid_reset_rfd", rfd, 1);
    chk("mid_reset_sel", sel, 0);
    chk("mid_reset_val", val, 0);
    run_txn(32'h0902_02C8, 1'b1, 1, 2, 0, 1);

    for (int t = 0; t < 25; t++) begin
      logic [31:0] d;
      logic m;
      int s, v;
      for (int i = 0; i < N; i++) d[i*8 +: 8] = 8'($urandom_range(0, 30));
      if (t % 5 == 0) d[$urandom_range(0, 3)*8 +: 8] = 8'($urandom_range(0, 30));
      m = 1'($urandom);
      ref_pick(d, m, s, v);
      run_txn(d, m, s, v, $urandom_range(0, 3), $urandom_range(0, 2));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pulse_sel_n.md
# pulse_sel_n

N-channel successor of the two-channel max/pulse consumer. Accepts one W-bit operand from each of N producers over a shared rfd/dav_ handshake. Selects either the maximum or the minimum operand, as chosen per transaction by `mode`. Emits a pulse on `out` lasting exactly that many clock cycles, and reports which channel won. Sits between the producer handshake fabric and downstream timed-pulse consumers.

## Interface
- `N`, default 2: number of input channels; legal range 2 to 16.
- `W`, default 8: operand width in bits; unsigned.
- `clock` input 1: sole clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clock`.
- `dav_` input N: per-channel data-available, active-low; bit i belongs to channel i.
- `data` input N*W: packed operands; channel i occupies bits [i*W+W-1 : i*W].
- `mode` input 1: 0 selects the maximum, 1 selects the minimum; sampled together with `data`.
- `rfd` output 1: ready-for-data; one signal shared by all producers.
- `out` output 1: timed pulse.
- `sel` output ceil(log2 N): index of the winning channel; held from capture until the next capture.
- `val` output W: winning operand; held like `sel`.

## Operation
- States: IDLE, ACK, PULSE.
- Reset (edge with `reset`=1), regardless of state or count:
  - outputs: `rfd`=1, `out`=0, `sel`=0, `val`=0;
  - internal: state IDLE, counter 0.
  - Reset overrides all other conditions on that edge.
- IDLE (`rfd`=1, `out`=0): wait until every `dav_` bit is 0. On that edge:
  - compare all N operands unsigned and pick the max (`mode`=0) or the min (`mode`=1);
  - ties go to the lowest channel index;
  - load the counter, `val` and `sel` with the winner;
  - set `rfd`=0 and go to ACK.
  - While only some `dav_` bits are low, stay in IDLE and capture nothing.
- ACK (`rfd`=0): wait until every `dav_` bit is 1. On that edge:
  - counter = 0: set `rfd`=1 and return to IDLE; no pulse is produced.
  - counter ≠ 0: set `out`=1 and go to PULSE.
  - A partial release stays in ACK.
- PULSE (`out`=1): on each edge the counter decrements.
  - On the edge where the counter equals 1: set `out`=0 and `rfd`=1, and go to IDLE.
  - `dav_`, `data` and `mode` are ignored in PULSE.
- Selection tree: combinational, log2(N) compare levels; every pair uses a W-bit unsigned comparison. The counter is W bits wide and never wraps.

## Timing
- Capture happens on the first edge at which all `dav_` bits are 0. `data` and `mode` must be stable on that edge.
- `rfd` falls on the capture edge. `out` rises on the edge at which all `dav_` bits are next seen high.
- `out` stays high for exactly V clock cycles, where V is the selected value (1 ≤ V ≤ 2^W−1).
- `rfd` rises on the same edge that `out` falls. The earliest next capture is the following edge.
- Zero operand: `rfd` returns to 1 on the release edge and `out` never pulses.
- Minimum transaction time is V+2 cycles, with producers that respond immediately.

## Test plan
- N=2, W=8, `mode`=0, data {ch1=7, ch0=3}: `sel`=1, `val`=7; `out` high for exactly 7 cycles; then `rfd`=1.
- N=4, `mode`=1, data {9, 2, 2, 200}, with ch3 on the left and ch0 on the right: winner is value 2. Channels 1 and 2 tie, so `sel`=1 (lowest index), `val`=2, and `out` is high for 2 cycles.
- Winner value 0 (`mode`=1, one channel carries 0): no `out` pulse; `rfd` returns to 1 on the release edge; `val`=0.
- Winner value 255 (`mode`=0, W=8): `out` is high for exactly 255 cycles and the counter does not wrap.
- Staggered `dav_`: channel 0 asserts 3 cycles before channel 1 → no capture until both are low; release staggered the same way → no pulse until both are high.
- Reset asserted mid-PULSE with the counter at 40: on the next edge `out`=0, `rfd`=1, state IDLE. A new transaction then completes normally.
